// File: rtl/jump_pc_ctrl.sv
// Program-counter controller: resolves branch, call, return, stall and halt
// using absolute targets from the jump lookup table, and sequences start/done.
module jump_pc_ctrl #(
  parameter int unsigned PC_W        = 12,
  parameter int unsigned PTR_W       = 5,
  parameter int unsigned STACK_DEPTH = 4,
  parameter int unsigned RESET_PC    = 0
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Start,
  input  logic             Stall,
  input  logic             Halt,
  input  logic             BranchEn,
  input  logic             Cond,
  input  logic             Call,
  input  logic             Ret,
  input  logic [PTR_W-1:0] TargetSel,
  output logic [PTR_W-1:0] JptrOut,
  input  logic [PC_W-1:0]  JumpIn,
  output logic [PC_W-1:0]  Prog_ctr,
  output logic             Running,
  output logic             Done,
  output logic             Err
);

  localparam int unsigned IDX_W = $clog2(STACK_DEPTH);
  // One extra bit so the pointer can represent "full" as well as "empty".
  localparam int unsigned SP_W  = IDX_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [PC_W-1:0] pc, pc_nxt, pc_inc;
  logic [SP_W-1:0] sp, sp_nxt, sp_dec;
  logic            err, err_nxt;
  logic            push_en;
  logic            stack_empty, stack_full;
  logic [PC_W-1:0] stack_q [STACK_DEPTH];

  assign JptrOut     = TargetSel;
  assign pc_inc      = pc + PC_W'(1);
  assign sp_dec      = sp - SP_W'(1);
  assign stack_empty = (sp == '0);
  assign stack_full  = (sp == SP_W'(STACK_DEPTH));

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    sp_nxt    = sp;
    err_nxt   = err;
    push_en   = 1'b0;
    unique case (state)
      ST_IDLE, ST_HALT: begin
        if (Start) begin
          state_nxt = ST_RUN;
          pc_nxt    = PC_W'(RESET_PC);
          sp_nxt    = '0;
          err_nxt   = 1'b0;
        end
      end
      ST_RUN: begin
        if (!Stall) begin
          if (Halt) begin
            state_nxt = ST_HALT;
          end else if (Ret) begin
            if (stack_empty) begin
              err_nxt   = 1'b1;
              state_nxt = ST_HALT;
            end else begin
              pc_nxt = stack_q[sp_dec[IDX_W-1:0]];
              sp_nxt = sp_dec;
            end
          end else if (Call) begin
            if (stack_full) begin
              err_nxt   = 1'b1;
              state_nxt = ST_HALT;
            end else begin
              push_en = 1'b1;
              sp_nxt  = sp + SP_W'(1);
              pc_nxt  = JumpIn;
            end
          end else if (BranchEn && Cond) begin
            pc_nxt = JumpIn;
          end else begin
            pc_nxt = pc_inc;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= ST_IDLE;
      pc    <= PC_W'(RESET_PC);
      sp    <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      sp    <= sp_nxt;
      err   <= err_nxt;
    end
  end

  // NOTE: the stack storage has no reset; the pointer alone defines which
  // entries are valid, so stale contents are never observed.
  always_ff @(posedge Clk) begin
    if (push_en) begin
      stack_q[sp[IDX_W-1:0]] <= pc_inc;
    end
  end

  assign Prog_ctr = pc;
  assign Running  = (state == ST_RUN);
  assign Done     = (state == ST_HALT);
  assign Err      = err;

endmodule

// File: tb/tb_jump_pc_ctrl.sv
// Self-checking bench for jump_pc_ctrl: a queue-based program model checked
// every cycle, plus directed scenarios with literal expected values.
module tb_jump_pc_ctrl;

  localparam int PC_W  = 12;
  localparam int PTR_W = 5;
  localparam int DEPTH = 4;
  localparam int RST_PC = 0;

  logic             Clk, Reset_n;
  logic             Start, Stall, Halt, BranchEn, Cond, Call, Ret;
  logic [PTR_W-1:0] TargetSel, JptrOut;
  logic [PC_W-1:0]  JumpIn, Prog_ctr;
  logic             Running, Done, Err;

  jump_pc_ctrl #(
    .PC_W(PC_W), .PTR_W(PTR_W), .STACK_DEPTH(DEPTH), .RESET_PC(RST_PC)
  ) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .Stall(Stall), .Halt(Halt),
    .BranchEn(BranchEn), .Cond(Cond), .Call(Call), .Ret(Ret),
    .TargetSel(TargetSel), .JptrOut(JptrOut), .JumpIn(JumpIn),
    .Prog_ctr(Prog_ctr), .Running(Running), .Done(Done), .Err(Err)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_vec = 0;
  int n_bad = 0;
  bit cmp_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Program-level model: mode 0 idle, 1 running, 2 halted; return stack as a queue.
  int m_mode = 0;
  int m_pc   = RST_PC;
  bit m_err  = 1'b0;
  int m_stk[$];

  always @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      m_mode = 0; m_pc = RST_PC; m_err = 1'b0; m_stk.delete();
    end else if (m_mode != 1) begin
      if (Start) begin
        m_mode = 1; m_pc = RST_PC; m_err = 1'b0; m_stk.delete();
      end
    end else if (!Stall) begin
      if (Halt) m_mode = 2;
      else if (Ret) begin
        if (m_stk.size() == 0) begin m_err = 1'b1; m_mode = 2; end
        else m_pc = m_stk.pop_back();
      end else if (Call) begin
        if (m_stk.size() == DEPTH) begin m_err = 1'b1; m_mode = 2; end
        else begin m_stk.push_back((m_pc + 1) % (1 << PC_W)); m_pc = int'(JumpIn); end
      end else if (BranchEn && Cond) m_pc = int'(JumpIn);
      else m_pc = (m_pc + 1) % (1 << PC_W);
    end
  end

  always @(negedge Clk) begin
    if (cmp_en) begin
      check("model_pc",      32'(Prog_ctr), 32'(m_pc));
      check("model_running", 32'(Running),  32'(m_mode == 1));
      check("model_done",    32'(Done),     32'(m_mode == 2));
      check("model_err",     32'(Err),      32'(m_err));
    end
  end

  // One instruction cycle: drive at the falling edge, return at the next one.
  task automatic step(input logic st, stl, hlt, br, cnd, cl, rt,
                      input logic [PTR_W-1:0] sel, input logic [PC_W-1:0] jin);
    Start = st; Stall = stl; Halt = hlt; BranchEn = br; Cond = cnd;
    Call = cl; Ret = rt; TargetSel = sel; JumpIn = jin;
    #1 check("jptr_out", 32'(JptrOut), 32'(sel));
    @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic idle();              step(0,0,0,0,0,0,0, 5'd0, '0);  endtask
  task automatic start();             step(1,0,0,0,0,0,0, 5'd0, '0);  endtask
  task automatic jump(input int t);   step(0,0,0,1,1,0,0, 5'd3, 12'(t)); endtask
  task automatic call(input int t);   step(0,0,0,0,0,1,0, 5'd7, 12'(t)); endtask
  task automatic ret();               step(0,0,0,0,0,0,1, 5'd0, '0);  endtask

  task automatic expect_out(input string name, input int pc, input bit run, input bit dn, input bit er);
    check({name, "_pc"},   32'(Prog_ctr), 32'(pc));
    check({name, "_run"},  32'(Running),  32'(run));
    check({name, "_done"}, 32'(Done),     32'(dn));
    check({name, "_err"},  32'(Err),      32'(er));
  endtask

  initial begin
    {Start, Stall, Halt, BranchEn, Cond, Call, Ret} = '0;
    TargetSel = '0; JumpIn = '0;
    Reset_n = 1'b1;
    #1 Reset_n = 1'b0;
    cmp_en = 1'b1;
    @(negedge Clk);
    expect_out("reset", 0, 0, 0, 0);
    #2 Reset_n = 1'b1;
    @(negedge Clk);

    // Start and sequential fetch
    start();   expect_out("start", 0, 1, 0, 0);
    idle();    check("seq1", 32'(Prog_ctr), 1);
    idle();    check("seq2", 32'(Prog_ctr), 2);
    jump(37);  check("to37", 32'(Prog_ctr), 37);

    // Asynchronous reset in the middle of a program
    #2 Reset_n = 1'b0;
    #1 expect_out("async_rst", 0, 0, 0, 0);
    @(negedge Clk);
    #2 Reset_n = 1'b1;
    @(negedge Clk);
    start();   check("restart_pc", 32'(Prog_ctr), 0);
    idle();    check("restart_seq", 32'(Prog_ctr), 1);

    // Conditional branch, taken and not taken
    jump(5);
    step(0,0,0,1,1,0,0, 5'd1, 12'd9);  check("br_taken", 32'(Prog_ctr), 9);
    jump(5);
    step(0,0,0,1,0,0,0, 5'd1, 12'd9);  check("br_not_taken", 32'(Prog_ctr), 6);

    // Call, run, return
    jump(20);
    call(86);  check("call", 32'(Prog_ctr), 86);
    idle();    check("call_seq1", 32'(Prog_ctr), 87);
    idle();    check("call_seq2", 32'(Prog_ctr), 88);
    ret();     check("ret", 32'(Prog_ctr), 21);

    // Overflow on the fifth nested call
    call(100); call(200); call(300); call(400);
    check("nest4", 32'(Prog_ctr), 400);
    call(500); expect_out("overflow", 400, 0, 1, 1);

    // Restart from HALT clears Err and the stack; Ret then underflows
    start();   expect_out("restart_halt", 0, 1, 0, 0);
    ret();     expect_out("underflow", 0, 0, 1, 1);

    // Halt beats Call and Branch
    start();
    call(239); check("call239", 32'(Prog_ctr), 239);
    step(0,0,1,1,1,1,0, 5'd2, 12'd50);
    expect_out("prio_halt", 239, 0, 1, 0);

    // Stall freezes everything, including a pending Halt and branch
    start();
    jump(10);
    step(0,1,1,1,1,1,0, 5'd4, 12'd241);
    expect_out("stall", 10, 1, 0, 0);

    // PC wrap and wrapped return address
    jump(4095);
    idle();    expect_out("wrap", 0, 1, 0, 0);
    jump(4095);
    call(7);   check("call_at_top", 32'(Prog_ctr), 7);
    ret();     expect_out("ret_wrap", 0, 1, 0, 0);

    // Start while running is ignored; Halt then holds the address
    start();   check("start_in_run", 32'(Prog_ctr), 1);
    step(0,0,1,0,0,0,0, 5'd0, '0);
    expect_out("halt", 1, 0, 1, 0);
    idle();    expect_out("halt_hold", 1, 0, 1, 0);

    cmp_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
